// File: rtl/fifo_cal_seq_pkg.sv
// Shared definitions for the calibration-sequencer FIFO and its upstream next-state logic.
package fifo_cal_seq_pkg;

    typedef enum logic [2:0] {
        ST_INIT     = 3'b000,
        ST_NO_OP    = 3'b001,
        ST_WRITE    = 3'b010,
        ST_WR_ERROR = 3'b011,
        ST_READ     = 3'b100,
        ST_RD_ERROR = 3'b101
    } state_t;

    localparam int FIFO_DEPTH = 8;
    localparam int PTR_W      = 3;
    localparam int CNT_W      = 4;

    localparam logic [CNT_W-1:0] CNT_FULL  = 4'd8;
    localparam logic [CNT_W-1:0] CNT_EMPTY = 4'd0;

    // Unused codes 110/111 collapse to NO_OP so they can never touch the FIFO.
    function automatic state_t decode_state(input logic [2:0] code);
        state_t st;
        case (code)
            3'b000:  st = ST_INIT;
            3'b001:  st = ST_NO_OP;
            3'b010:  st = ST_WRITE;
            3'b011:  st = ST_WR_ERROR;
            3'b100:  st = ST_READ;
            3'b101:  st = ST_RD_ERROR;
            default: st = ST_NO_OP;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/fifo_cal_seq_mem.sv
// fifo_mem: 8-entry register file, one synchronous write port, one asynchronous read port, no reset.
module fifo_mem
    import fifo_cal_seq_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [PTR_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [PTR_W-1:0]  i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_cal_seq.sv
// fifo_cal_seq: 8-deep FIFO datapath driven by an external next-state code.
// Optional macro FIFO_DOUT_CLEAR_EN: zero d_out on every edge without a successful read.
module fifo_cal_seq
    import fifo_cal_seq_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        next_state,
    input  logic [DATA_W-1:0] d_in,
    output logic [2:0]        state,
    output logic [3:0]        data_count,
    output logic [2:0]        head,
    output logic [2:0]        tail,
    output logic              full,
    output logic              empty,
    output logic              wr_ack,
    output logic              wr_err,
    output logic              rd_ack,
    output logic              rd_err,
    output logic [DATA_W-1:0] d_out
);

    state_t              r_state;
    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;
    logic [CNT_W-1:0]    r_count;
    logic                r_wr_ack;
    logic                r_wr_err;
    logic                r_rd_ack;
    logic                r_rd_err;
    logic [DATA_W-1:0]   r_dout;

    state_t              w_state_nxt;
    logic                w_do_write;
    logic                w_do_read;
    logic                w_wr_err_nxt;
    logic                w_rd_err_nxt;
    logic [PTR_W-1:0]    w_head_nxt;
    logic [PTR_W-1:0]    w_tail_nxt;
    logic [CNT_W-1:0]    w_count_nxt;
    logic [DATA_W-1:0]   w_rd_data;
    logic                w_mem_we;

    always_comb begin
        w_state_nxt  = decode_state(next_state);
        w_do_write   = 1'b0;
        w_do_read    = 1'b0;
        w_wr_err_nxt = 1'b0;
        w_rd_err_nxt = 1'b0;
        w_head_nxt   = r_head;
        w_tail_nxt   = r_tail;
        w_count_nxt  = r_count;
        case (w_state_nxt)
            ST_WRITE: begin
                if (r_count != CNT_FULL) begin
                    w_do_write  = 1'b1;
                    w_tail_nxt  = r_tail + 3'd1;
                    w_count_nxt = r_count + 4'd1;
                end else begin
                    w_wr_err_nxt = 1'b1;
                end
            end
            ST_READ: begin
                if (r_count != CNT_EMPTY) begin
                    w_do_read   = 1'b1;
                    w_head_nxt  = r_head + 3'd1;
                    w_count_nxt = r_count - 4'd1;
                end else begin
                    w_rd_err_nxt = 1'b1;
                end
            end
            ST_WR_ERROR: w_wr_err_nxt = 1'b1;
            ST_RD_ERROR: w_rd_err_nxt = 1'b1;
            default: ;
        endcase
    end

    // A write coinciding with reset is discarded, so the memory port is gated too.
    assign w_mem_we = w_do_write & reset_n;

    fifo_mem #(.DATA_W(DATA_W)) u_mem (
        .i_clk   (clk),
        .i_we    (w_mem_we),
        .i_waddr (r_tail),
        .i_wdata (d_in),
        .i_raddr (r_head),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= ST_INIT;
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_wr_ack <= 1'b0;
            r_wr_err <= 1'b0;
            r_rd_ack <= 1'b0;
            r_rd_err <= 1'b0;
            r_dout   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_head   <= w_head_nxt;
            r_tail   <= w_tail_nxt;
            r_count  <= w_count_nxt;
            r_wr_ack <= w_do_write;
            r_wr_err <= w_wr_err_nxt;
            r_rd_ack <= w_do_read;
            r_rd_err <= w_rd_err_nxt;
`ifdef FIFO_DOUT_CLEAR_EN
            r_dout   <= w_do_read ? w_rd_data : '0;
`else
            if (w_do_read) begin
                r_dout <= w_rd_data;
            end
`endif
        end
    end

    assign state      = r_state;
    assign data_count = r_count;
    assign head       = r_head;
    assign tail       = r_tail;
    assign full       = (r_count == CNT_FULL);
    assign empty      = (r_count == CNT_EMPTY);
    assign wr_ack     = r_wr_ack;
    assign wr_err     = r_wr_err;
    assign rd_ack     = r_rd_ack;
    assign rd_err     = r_rd_err;
    assign d_out      = r_dout;

endmodule

// File: tb/tb_fifo_cal_seq.sv
// Directed self-checking bench for fifo_cal_seq; expected values are hand-computed.
module tb_fifo_cal_seq;

    localparam logic [2:0] C_INIT  = 3'b000;
    localparam logic [2:0] C_NOOP  = 3'b001;
    localparam logic [2:0] C_WR    = 3'b010;
    localparam logic [2:0] C_WRERR = 3'b011;
    localparam logic [2:0] C_RD    = 3'b100;
    localparam logic [2:0] C_RDERR = 3'b101;

    logic        clk;
    logic        reset_n;
    logic [2:0]  next_state;
    logic [31:0] d_in;
    logic [2:0]  state;
    logic [3:0]  data_count;
    logic [2:0]  head;
    logic [2:0]  tail;
    logic        full;
    logic        empty;
    logic        wr_ack;
    logic        wr_err;
    logic        rd_ack;
    logic        rd_err;
    logic [31:0] d_out;

    int checks = 0;
    int errors = 0;

    fifo_cal_seq #(.DATA_W(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .next_state (next_state),
        .d_in       (d_in),
        .state      (state),
        .data_count (data_count),
        .head       (head),
        .tail       (tail),
        .full       (full),
        .empty      (empty),
        .wr_ack     (wr_ack),
        .wr_err     (wr_err),
        .rd_ack     (rd_ack),
        .rd_err     (rd_err),
        .d_out      (d_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    // Drive one code for one edge, then settle 1 time unit past the edge.
    task automatic applyStimulus(input logic [2:0] ns, input logic [31:0] data);
        next_state = ns;
        d_in       = data;
        @(posedge clk);
        #1;
    endtask

    task automatic checkFlags(input string tag, input logic [3:0] exp);
        checkOutput({tag, "_flags"}, {28'd0, wr_ack, wr_err, rd_ack, rd_err}, {28'd0, exp});
    endtask

    logic [31:0] expHold;

    initial begin
        reset_n    = 1'b0;
        next_state = C_WR;
        d_in       = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        checkOutput("rst_state", {29'd0, state}, 32'd0);
        checkOutput("rst_count", {28'd0, data_count}, 32'd0);
        checkOutput("rst_head", {29'd0, head}, 32'd0);
        checkOutput("rst_tail", {29'd0, tail}, 32'd0);
        checkOutput("rst_empty", {31'd0, empty}, 32'd1);
        checkOutput("rst_full", {31'd0, full}, 32'd0);
        checkFlags("rst", 4'b0000);
        checkOutput("rst_dout", d_out, 32'd0);

        reset_n = 1'b1;
        applyStimulus(C_RD, 32'h0);
        checkOutput("erd_state", {29'd0, state}, 32'd4);
        checkFlags("erd", 4'b0001);
        checkOutput("erd_count", {28'd0, data_count}, 32'd0);
        checkOutput("erd_head", {29'd0, head}, 32'd0);
        checkOutput("erd_dout", d_out, 32'd0);

        for (int k = 1; k <= 8; k++) begin
            applyStimulus(C_WR, 32'h11 * k);
            checkFlags($sformatf("wr%0d", k), 4'b1000);
            checkOutput($sformatf("wr%0d_count", k), {28'd0, data_count}, k);
        end
        checkOutput("ovf_full", {31'd0, full}, 32'd1);
        checkOutput("ovf_tail", {29'd0, tail}, 32'd0);
        applyStimulus(C_WR, 32'h99);
        checkFlags("ovf9", 4'b0100);
        checkOutput("ovf9_count", {28'd0, data_count}, 32'd8);
        checkOutput("ovf9_tail", {29'd0, tail}, 32'd0);

        for (int k = 1; k <= 3; k++) begin
            applyStimulus(C_RD, 32'h0);
            checkFlags($sformatf("rd%0d", k), 4'b0010);
            checkOutput($sformatf("rd%0d_dout", k), d_out, 32'h11 * k);
        end
        checkOutput("wrap_head3", {29'd0, head}, 32'd3);
        checkOutput("wrap_count5", {28'd0, data_count}, 32'd5);
        for (int k = 1; k <= 3; k++) applyStimulus(C_WR, 32'hA0 + k);
        checkOutput("wrap_tail", {29'd0, tail}, 32'd3);
        checkOutput("wrap_count8", {28'd0, data_count}, 32'd8);
        for (int k = 4; k <= 8; k++) begin
            applyStimulus(C_RD, 32'h0);
            checkOutput($sformatf("wrap_rd_%0d", k), d_out, 32'h11 * k);
        end
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(C_RD, 32'h0);
            checkFlags($sformatf("wrap_rdA%0d", k), 4'b0010);
            checkOutput($sformatf("wrap_rdA%0d_dout", k), d_out, 32'hA0 + k);
        end
        checkOutput("wrap_empty", {31'd0, empty}, 32'd1);
        checkOutput("wrap_headend", {29'd0, head}, 32'd3);

        for (int k = 1; k <= 4; k++) applyStimulus(C_WR, 32'hB0 + k);
        checkOutput("fill4_tail", {29'd0, tail}, 32'd7);
`ifdef FIFO_DOUT_CLEAR_EN
        expHold = 32'h0;
`else
        expHold = 32'hA3;
`endif
        checkOutput("hold_after_wr", d_out, expHold);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(C_NOOP, 32'hFFFF_FFFF);
            checkFlags($sformatf("noop%0d", k), 4'b0000);
            checkOutput($sformatf("noop%0d_count", k), {28'd0, data_count}, 32'd4);
            checkOutput($sformatf("noop%0d_ptrs", k), {26'd0, head, tail}, {26'd0, 3'd3, 3'd7});
        end
        checkOutput("noop_state", {29'd0, state}, 32'd1);

        applyStimulus(3'b110, 32'h0);
        checkOutput("code6_state", {29'd0, state}, 32'd1);
        applyStimulus(3'b111, 32'h0);
        checkFlags("code7", 4'b0000);
        checkOutput("code7_count", {28'd0, data_count}, 32'd4);
        applyStimulus(C_WRERR, 32'h0);
        checkFlags("wrerr", 4'b0100);
        checkOutput("wrerr_count", {28'd0, data_count}, 32'd4);
        applyStimulus(C_RDERR, 32'h0);
        checkFlags("rderr", 4'b0001);
        checkOutput("rderr_ptrs", {26'd0, head, tail}, {26'd0, 3'd3, 3'd7});
        applyStimulus(C_INIT, 32'h0);
        checkOutput("init_state", {29'd0, state}, 32'd0);
        checkOutput("init_count", {28'd0, data_count}, 32'd4);

        applyStimulus(C_RD, 32'h0);
        checkOutput("macro_rd", d_out, 32'hB1);
        applyStimulus(C_NOOP, 32'h0);
`ifdef FIFO_DOUT_CLEAR_EN
        expHold = 32'h0;
`else
        expHold = 32'hB1;
`endif
        checkOutput("macro_noop", d_out, expHold);

        applyStimulus(C_WR, 32'hC1);
        checkOutput("twrap_tail", {29'd0, tail}, 32'd0);
        checkOutput("twrap_count", {28'd0, data_count}, 32'd4);

        reset_n = 1'b0;
        applyStimulus(C_RD, 32'h0);
        checkOutput("rst2_count", {28'd0, data_count}, 32'd0);
        checkOutput("rst2_ptrs", {26'd0, head, tail}, 32'd0);
        checkFlags("rst2", 4'b0000);
        checkOutput("rst2_dout", d_out, 32'd0);
        reset_n = 1'b1;
        applyStimulus(C_NOOP, 32'h0);
        checkOutput("post_rst_state", {29'd0, state}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
